// File: rtl/alu_operand_loader.sv
// Operand-entry stage for the 4-bit ALU: debounced push-button steps a three-state
// sequencer that latches operand A, operand B and Cin from the board switches.
module alu_operand_loader #(
    parameter int N          = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic         btn_raw,
    input  logic         cin_sw,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         Cin,
    output logic         valid,
    output logic [1:0]   stage
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'b00,
        ST_LOAD_B  = 2'b01,
        ST_READY   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // Handshake: press_q is a single-cycle strobe; the sequencer acts on it
    // unconditionally on the edge where it is high (no back-pressure exists).

    logic          sync1_q;
    logic          btn_s_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_dly_q;
    logic          press_q;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          cin_q, cin_d;

    // Debounce: count the cycles btn_s disagrees with the accepted level;
    // any agreement restarts the count, so short glitches never flip it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (btn_s_q != stable_q) begin
            if (cnt_q == DEB_LAST) begin
                stable_d = btn_s_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            btn_s_q      <= 1'b0;
            stable_q     <= 1'b0;
            cnt_q        <= '0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            btn_s_q      <= sync1_q;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        case (state_q)
            ST_LOAD_A: begin
                if (press_q) begin
                    a_d     = sw;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (press_q) begin
                    b_d     = sw;
                    cin_d   = cin_sw;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // Reloading A reopens the set, so valid drops until B is re-entered.
                if (press_q) begin
                    a_d     = sw;
                    state_d = ST_LOAD_B;
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                a_d     = '0;
                b_d     = '0;
                cin_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign Cin   = cin_q;
    assign valid = (state_q == ST_READY);
    assign stage = state_q;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Upstream operand-entry stage for the 4-bit ALU datapath: captures operand A, operand B and the Cin select from board switches, one operand per debounced push-button press, and holds them steady as registered inputs to the ALU function units (including the NOT unit, which inverts B when Cin=1 and A when Cin=0). A three-state sequencer walks the user through LOAD_A, LOAD_B and READY. `valid` marks the cycles in which the held operand set is complete.

## Interface
- `N`, 4, operand width; must match the ALU width.
- `DEB_CYCLES`, 1000000, number of consecutive cycles a synchronized button level must hold before it is accepted; must be at least 1. The default is 10 ms at 100 MHz.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sw`  in  N  operand switches; asynchronous, sampled only on a press event.
- `btn_raw`  in  1  load push-button; asynchronous and bouncy; active-high.
- `cin_sw`  in  1  Cin select switch; asynchronous, sampled only on a press event.
- `A`  out  N  registered operand A.
- `B`  out  N  registered operand B.
- `Cin`  out  1  registered Cin/operand select.
- `valid`  out  1  high only while in READY.
- `stage`  out  2  current state: 00 LOAD_A, 01 LOAD_B, 10 READY.

## Operation
- **Button path:**
  - Synchronizer: 2-flop synchronizer `btn_raw` → `btn_s`.
  - Debounce: register `stable` plus a counter of width $clog2(DEB_CYCLES+1).
    - While `btn_s == stable`: counter = 0.
    - Otherwise the counter increments. When it would reach `DEB_CYCLES`, `stable` takes `btn_s` and the counter clears.
  - Edge detect: `press` is a registered one-cycle pulse, `stable & ~stable_d`. Only rising edges act; a held button never repeats; release is debounced but otherwise ignored.
- **Sampling:** `sw` and `cin_sw` are sampled directly on the edge where `press` is high. No synchronizer is used on them; the operator holds the switches steady.
- **FSM** (all transitions occur only on `press`):
  - LOAD_A: `A <= sw`; go to LOAD_B.
  - LOAD_B: `B <= sw`, `Cin <= cin_sw`; go to READY.
  - READY: `A <= sw`; `B` and `Cin` hold; go to LOAD_B, so `valid` drops.
  - Encoding 11 (illegal state): next edge goes to LOAD_A and clears `A`, `B` and `Cin` to 0.
- **Output holds:** outputs not named in a transition hold their value. `A`, `B` and `Cin` never change except on a press edge, or on illegal-state recovery.
- **Reset** (`rst_n` low, at any time, including mid-debounce or mid-sequence):
  - `A`, `B`, `Cin`, `valid`, `stage`, the synchronizer flops, `stable`, `stable_d`, `press` and the counter all go to 0 immediately.
  - A press in progress is discarded.
  - After reset release, a button already held high must still satisfy the full debounce before it counts as a press.

## Timing
- **Press latency:** `btn_raw` goes high before edge k and stays high.
  - `btn_s` goes high at edge k+1.
  - `stable` goes high at edge k+1+DEB_CYCLES.
  - `press` is high during the cycle after edge k+2+DEB_CYCLES.
  - Operands are captured and `stage`/`valid` update at edge k+3+DEB_CYCLES.
- **Glitch rejection:** any excursion of `btn_s` shorter than DEB_CYCLES cycles is rejected, and the counter restarts from 0.
- **Press spacing:** a release must also persist DEB_CYCLES cycles before the next rising edge is possible. Minimum press spacing is therefore about 2×DEB_CYCLES+2 cycles.
- **Valid timing:** `valid` rises on the same edge that loads `B`/`Cin`, and falls on the same edge that loads a new `A` from READY.
- **Combinational path:** there is none from any input to any output.

## Test plan
All scenarios use DEB_CYCLES=4 and N=4.
- **Reset:** assert `rst_n`=0 mid-run → `A`=0, `B`=0, `Cin`=0, `valid`=0, `stage`=00 without waiting for a clock edge.
- **Full sequence:**
  - Clean press with `sw`=1010 → `A`=1010, `stage`=01, exactly 7 edges after `btn_raw` rises (k+3+DEB_CYCLES).
  - Second press with `sw`=0110, `cin_sw`=1 → `B`=0110, `Cin`=1, `valid`=1, `stage`=10.
- **Bounce rejection:**
  - Pulses on `btn_raw` of 1–3 cycles separated by 1–2 low cycles → no `press`; `stage` is unchanged.
  - Then hold high → exactly one capture.
- **Hold without repeat:** hold `btn_raw` high for 50 cycles from LOAD_A → exactly one transition (to LOAD_B); `A` is captured once.
- **Reload from READY:**
  - In READY (`A`=1010, `B`=0110, `Cin`=1), press with `sw`=1111 → `A`=1111, `B`=0110, `Cin`=1, `valid`=0, `stage`=01.
  - Next press with `sw`=0001, `cin_sw`=0 → `B`=0001, `Cin`=0, `valid`=1.
- **Reset mid-debounce:**
  - Raise `btn_raw`, then pulse `rst_n` low 2 edges later and release it while the button is still held → no capture until a full 4-cycle debounce completes after reset release.
  - The capture lands in `A` (`stage` 00→01).
